// File: rtl/bpsk_frame_ctrl.sv
// BPSK frame controller: takes payload bytes over a valid/ready handshake,
// brings up the mixer, then sends a preamble, the payload bits MSB first and
// a zero guard. Every symbol lasts SPS clock cycles.
// Optional feature: define BPSK_DIFF_ENC_EN to differentially encode the
// payload bits. The reference starts at 0 on each entry to DATA.
module bpsk_frame_ctrl #(
    parameter int SPS           = 64,
    parameter int PREAMBLE_SYMS = 16,
    parameter int GUARD_SYMS    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_byte,
    input  logic       tx_last,
    output logic       tx_ready,
    input  logic       ena_mod,
    output logic       mod_ena,
    output logic       data,
    output logic       sym_strobe,
    output logic       busy,
    output logic       underrun,
    output logic       done
);

    typedef enum logic [2:0] {IDLE, WAIT_MOD, PREAMBLE, DATA, GUARD} state_t;

    localparam int CNT_W   = (SPS > 2) ? $clog2(SPS) : 1;
    localparam int SYM_MAX = (PREAMBLE_SYMS > GUARD_SYMS) ? PREAMBLE_SYMS : GUARD_SYMS;
    localparam int SYM_W   = $clog2(SYM_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);
    localparam logic [SYM_W-1:0] PRE_LAST = SYM_W'(PREAMBLE_SYMS - 1);
    localparam logic [SYM_W-1:0] GRD_LAST = SYM_W'(GUARD_SYMS - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [SYM_W-1:0] sym_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       hold_byte;
    logic             hold_last;
    logic             hold_full;
    logic [7:0]       shift_reg;
    logic             shift_last;
    logic             payload_bit;

    logic accept, sym_end, pre_end, byte_end, guard_end, load_shift;

    assign accept     = tx_valid && !hold_full;
    assign tx_ready   = !hold_full;
    assign busy       = (state != IDLE);
    assign sym_end    = (cnt == CNT_LAST);
    assign pre_end    = (state == PREAMBLE) && sym_end && (sym_cnt == PRE_LAST);
    assign byte_end   = (state == DATA) && sym_end && (bit_cnt == 3'd7);
    assign guard_end  = (state == GUARD) && sym_end && (sym_cnt == GRD_LAST);
    assign load_shift = pre_end || (byte_end && hold_full);

`ifdef BPSK_DIFF_ENC_EN
    logic enc_ref;

    // Differential reference: last encoded payload symbol, zeroed as DATA starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_ref <= 1'b0;
        end else if (pre_end) begin
            enc_ref <= 1'b0;
        end else if ((state == DATA) && sym_end) begin
            enc_ref <= shift_reg[7] ^ enc_ref;
        end
    end

    assign payload_bit = shift_reg[7] ^ enc_ref;
`else
    assign payload_bit = shift_reg[7];
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state outputs
    always_comb begin
        state_nxt  = state;
        mod_ena    = 1'b0;
        data       = 1'b0;
        sym_strobe = 1'b0;
        underrun   = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full || accept) begin
                    state_nxt = WAIT_MOD;
                end
            end
            WAIT_MOD: begin
                mod_ena = 1'b1;
                if (ena_mod) begin
                    state_nxt = PREAMBLE;
                end
            end
            PREAMBLE: begin
                mod_ena    = 1'b1;
                sym_strobe = (cnt == '0);
                data       = ~sym_cnt[0];
                if (pre_end) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                mod_ena    = 1'b1;
                sym_strobe = (cnt == '0);
                data       = payload_bit;
                if (byte_end && !hold_full) begin
                    state_nxt = GUARD;
                    underrun  = !shift_last;
                end
            end
            GUARD: begin
                mod_ena    = 1'b1;
                sym_strobe = (cnt == '0);
                if (guard_end) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Cycle-in-symbol, symbol and bit counters; parked at zero outside symbol states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            sym_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                PREAMBLE: begin
                    cnt     <= sym_end ? '0 : cnt + 1'b1;
                    bit_cnt <= '0;
                    if (sym_end) begin
                        sym_cnt <= pre_end ? '0 : sym_cnt + 1'b1;
                    end
                end
                DATA: begin
                    cnt     <= sym_end ? '0 : cnt + 1'b1;
                    sym_cnt <= '0;
                    if (sym_end) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                GUARD: begin
                    cnt     <= sym_end ? '0 : cnt + 1'b1;
                    bit_cnt <= '0;
                    if (sym_end) begin
                        sym_cnt <= guard_end ? '0 : sym_cnt + 1'b1;
                    end
                end
                default: begin
                    cnt     <= '0;
                    sym_cnt <= '0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    // Holding register fills on handshake; shift register reloads from it or shifts MSB out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_byte  <= '0;
            hold_last  <= 1'b0;
            hold_full  <= 1'b0;
            shift_reg  <= '0;
            shift_last <= 1'b0;
        end else begin
            if (accept) begin
                hold_byte <= tx_byte;
                hold_last <= tx_last;
                hold_full <= 1'b1;
            end
            if (load_shift) begin
                shift_reg  <= hold_byte;
                shift_last <= hold_last;
                hold_full  <= 1'b0;
            end else if ((state == DATA) && sym_end) begin
                shift_reg <= {shift_reg[6:0], 1'b0};
            end
        end
    end

endmodule

// File: doc/bpsk_frame_ctrl.md
BPSK_FRAME_CTRL -- requirements
Module: bpsk_frame_ctrl

Interface
REQ-001 Parameter SPS, default 64: clock cycles per BPSK symbol (>=2).
REQ-002 Parameter PREAMBLE_SYMS, default 16: preamble length in symbols (even, >=2).
REQ-003 Parameter GUARD_SYMS, default 4: trailing guard length in symbols (>=1).
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 tx_valid  in  1  requester offers tx_byte/tx_last.
REQ-007 tx_byte  in  8  payload byte, transmitted MSB first.
REQ-008 tx_last  in  1  offered byte is the last byte of the frame.
REQ-009 tx_ready  out  1  holding register empty; byte accepted when tx_valid&&tx_ready.
REQ-010 ena_mod  in  1  Mixer acknowledge that modulation is active.
REQ-011 mod_ena  out  1  enable to Mixer.
REQ-012 data  out  1  symbol bit to Mixer.
REQ-013 sym_strobe  out  1  one-cycle pulse on the first cycle of every symbol.
REQ-014 busy  out  1  high whenever the state is not IDLE.
REQ-015 underrun  out  1  one-cycle pulse when a payload byte is late.
REQ-016 done  out  1  one-cycle pulse on the last cycle of the guard.

Function
REQ-017 States: IDLE, WAIT_MOD, PREAMBLE, DATA, GUARD; the block SHALL use one holding register (8b+last) and one 8-bit shift register.
REQ-018 tx_ready SHALL equal holding-register-empty in every state, GUARD included; a byte accepted in GUARD is held for the next frame.
REQ-019 IDLE: mod_ena=0, data=0; on acceptance at cycle t -> WAIT_MOD at t+1 with mod_ena=1 from t+1.
REQ-020 WAIT_MOD: mod_ena=1, data=0; the first cycle with ena_mod=1 sampled -> PREAMBLE; there is no timeout.
REQ-021 PREAMBLE: PREAMBLE_SYMS symbols alternating 1,0,1,0..., first symbol 1, each held exactly SPS cycles.
REQ-022 End of preamble: holding moves to shift register (tx_ready rises next cycle) -> DATA.
REQ-023 DATA: 8 symbols per byte, MSB first, SPS cycles each; no idle cycle between consecutive bytes.
REQ-024 End of byte, holding full -> reload shift register, stay in DATA; else shifted byte had last=1 -> GUARD; else pulse underrun and -> GUARD.
REQ-025 GUARD: data=0, mod_ena=1 for GUARD_SYMS symbols; done pulses on final cycle; -> IDLE next cycle (mod_ena=0).
REQ-026 Returning to IDLE with holding full SHALL start a new frame on the next cycle (-> WAIT_MOD).
REQ-027 Symbol cycle counter 0..SPS-1 wraps; sym_strobe asserts when counter==0 in PREAMBLE, DATA, GUARD.
REQ-028 ena_mod falling after WAIT_MOD SHALL be ignored.

Reset
REQ-029 rst_n low SHALL immediately force IDLE; counters, shift and holding registers cleared; mod_ena, data, sym_strobe, busy, underrun, done = 0; tx_ready = 1.
REQ-030 Reset mid-frame SHALL discard the frame without a done or underrun pulse; operation resumes on the first clk edge after rst_n rises.

Configuration
REQ-031 Macro BPSK_DIFF_ENC_EN defined: DATA-state payload bits are differentially encoded, data = bit XOR previous encoded data, reference cleared to 0 on DATA entry; preamble and guard not encoded.
REQ-032 Macro BPSK_DIFF_ENC_EN undefined: data = raw payload bit; no encoder register exists.

Verification (SPS=4, PREAMBLE_SYMS=4, GUARD_SYMS=2)
REQ-033 Single byte 0xA5 last=1, ena_mod tied 1 -> data 1,0,1,0 then 1,0,1,0,0,1,0,1 then 0,0 (4 cycles each); done once; busy 57 cycles.
REQ-034 Bytes 0x0F,0xF0(last) back-to-back -> 16 contiguous data symbols 0000111111110000; no underrun.
REQ-035 Byte 0x81 last=0, no second byte -> underrun pulse at end of byte 1, then guard, done, IDLE.
REQ-036 ena_mod held 0 for 20 cycles after acceptance -> mod_ena=1, data=0, no sym_strobe until ena_mod=1.
REQ-037 rst_n low during DATA -> mod_ena=0 same cycle; no done; fresh frame afterwards transmits correctly.
REQ-038 BPSK_DIFF_ENC_EN, byte 0xA5 -> payload data symbols 1,1,0,0,0,1,1,0.
